// File: rtl/octurdle_pkg.sv
// Shared types and constants for the octurdle game controller.
// Holds the FSM state encoding, display source codes and default parameters.
package octurdle_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        NEW_ROUND = 3'd1,
        GUESS     = 3'd2,
        COMPARE   = 3'd3,
        CHECK     = 3'd4,
        WIN_SHOW  = 3'd5,
        LOSE_SHOW = 3'd6
    } state_t;

    localparam logic [1:0] SRC_SCORE  = 2'd0;
    localparam logic [1:0] SRC_SWITCH = 2'd1;
    localparam logic [1:0] SRC_CMP    = 2'd2;
    localparam logic [1:0] SRC_RAND   = 2'd3;

    localparam int DEF_MAX_GUESSES  = 6;
    localparam int DEF_WIN_HOLD_CYC = 100_000_000;

    // Display source for the current state. User requests only apply outside the show states.
    function automatic logic [1:0] sel_src(input state_t st, input logic score,
                                           input logic rand_req, input logic switches);
        logic [1:0] src;
        src = SRC_CMP;
        if (st == LOSE_SHOW)
            src = SRC_RAND;
        else if (st == WIN_SHOW)
            src = SRC_CMP;
        else if (score)
            src = SRC_SCORE;
        else if (rand_req)
            src = SRC_RAND;
        else if (switches)
            src = SRC_SWITCH;
        else if (st == IDLE)
            src = SRC_SCORE;
        return src;
    endfunction

endpackage

// File: rtl/game_sequencer_hold_timer.sv
// Win-display hold timer: counts up from 0 after start, done flags the last held cycle.
// A new start always restarts the count from 0.
module hold_timer #(
    parameter int CYCLES = 8
) (
    input  logic clk,
    input  logic Reset,
    input  logic start,
    output logic done
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          running;

    assign done = running && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
        end else if (done) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (running) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer for the guessing game: secret generation, guess compare,
// win celebration hold and lose reveal, plus display source selection.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | waiting for first Enter press
// NEW_ROUND | one cycle: gen_rand pulse, reload guesses
// GUESS     | waiting for Enter to submit a guess
// COMPARE   | comparator working on the latched guess
// CHECK     | win flag sampled, score/guess bookkeeping
// WIN_SHOW  | celebration display held for WIN_HOLD_CYC
// LOSE_SHOW | secret revealed until next Enter press
module game_sequencer
    import octurdle_pkg::*;
#(
    parameter int MAX_GUESSES  = DEF_MAX_GUESSES,
    parameter int WIN_HOLD_CYC = DEF_WIN_HOLD_CYC
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Enter,
    input  logic       win,
    input  logic       disp_score,
    input  logic       disp_random,
    input  logic       disp_switches,
    output logic       gen_rand,
    output logic       cmp_en,
    output logic       score_inc,
    output logic       score_clr,
    output logic [1:0] sel_bits,
    output logic       sseg_mode,
    output logic [2:0] guesses_left
);

    state_t state;
    logic   enter_prev;
    logic   enter_evt;
    logic   hold_start;
    logic   hold_done;

    assign enter_evt  = Enter && !enter_prev;
    assign hold_start = (state == CHECK) && win;

    hold_timer #(
        .CYCLES (WIN_HOLD_CYC)
    ) u_hold (
        .clk   (clk),
        .Reset (Reset),
        .start (hold_start),
        .done  (hold_done)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= IDLE;
            enter_prev   <= 1'b1;
            gen_rand     <= 1'b0;
            cmp_en       <= 1'b0;
            score_inc    <= 1'b0;
            score_clr    <= 1'b0;
            sel_bits     <= SRC_SCORE;
            sseg_mode    <= 1'b0;
            guesses_left <= 3'd0;
        end else begin
            enter_prev <= Enter;
            gen_rand   <= 1'b0;
            cmp_en     <= 1'b0;
            score_inc  <= 1'b0;
            score_clr  <= 1'b0;
            sel_bits   <= sel_src(state, disp_score, disp_random, disp_switches);

            case (state)
                IDLE: begin
                    if (enter_evt) begin
                        gen_rand <= 1'b1;
                        state    <= NEW_ROUND;
                    end
                end
                NEW_ROUND: begin
                    guesses_left <= 3'(MAX_GUESSES);
                    state        <= GUESS;
                end
                GUESS: begin
                    if (enter_evt) begin
                        cmp_en <= 1'b1;
                        state  <= COMPARE;
                    end
                end
                COMPARE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (win) begin
                        score_inc <= 1'b1;
                        sseg_mode <= 1'b1;
                        state     <= WIN_SHOW;
                    end else if (guesses_left <= 3'd1) begin
                        // Last guess spent (or counter already empty): clamp at 0
                        guesses_left <= 3'd0;
                        score_clr    <= 1'b1;
                        sel_bits     <= SRC_RAND;
                        state        <= LOSE_SHOW;
                    end else begin
                        guesses_left <= guesses_left - 3'd1;
                        state        <= GUESS;
                    end
                end
                WIN_SHOW: begin
                    if (hold_done) begin
                        sseg_mode <= 1'b0;
                        gen_rand  <= 1'b1;
                        state     <= NEW_ROUND;
                    end
                end
                LOSE_SHOW: begin
                    sel_bits <= SRC_RAND;
                    if (enter_evt) begin
                        gen_rand <= 1'b1;
                        state    <= NEW_ROUND;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with MAX_GUESSES=3, WIN_HOLD_CYC=8.
module tb_game_sequencer;
    import octurdle_pkg::*;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Enter = 1'b0;
    logic       win = 1'b0;
    logic       disp_score = 1'b0;
    logic       disp_random = 1'b0;
    logic       disp_switches = 1'b0;
    logic       gen_rand;
    logic       cmp_en;
    logic       score_inc;
    logic       score_clr;
    logic [1:0] sel_bits;
    logic       sseg_mode;
    logic [2:0] guesses_left;

    int total = 0;
    int bad   = 0;

    game_sequencer #(
        .MAX_GUESSES  (3),
        .WIN_HOLD_CYC (8)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Enter         (Enter),
        .win           (win),
        .disp_score    (disp_score),
        .disp_random   (disp_random),
        .disp_switches (disp_switches),
        .gen_rand      (gen_rand),
        .cmp_en        (cmp_en),
        .score_inc     (score_inc),
        .score_clr     (score_clr),
        .sel_bits      (sel_bits),
        .sseg_mode     (sseg_mode),
        .guesses_left  (guesses_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int pulses;

        // reset state
        tick();
        tick();
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_outs", {gen_rand, cmp_en, score_inc, score_clr, sseg_mode}, 0);
        chk("rst_sel", sel_bits, 0);
        chk("rst_guesses", guesses_left, 0);
        Reset = 1'b0;
        tick();

        // new round
        Enter = 1'b1;
        tick();
        chk("newround_gen_rand", gen_rand, 1);
        chk("newround_state", 32'(dut.state), 32'(NEW_ROUND));
        Enter = 1'b0;
        tick();
        chk("gen_rand_width", gen_rand, 0);
        chk("guess_state", 32'(dut.state), 32'(GUESS));
        chk("guesses_loaded", guesses_left, 3);
        tick();
        chk("guess_sel_default", sel_bits, 2);

        // winning guess
        Enter = 1'b1;
        tick();
        chk("win_cmp_en", cmp_en, 1);
        Enter = 1'b0;
        win = 1'b1;
        tick();
        chk("win_cmp_en_width", cmp_en, 0);
        chk("check_state", 32'(dut.state), 32'(CHECK));
        tick();
        win = 1'b0;
        chk("score_inc", score_inc, 1);
        chk("win_show_state", 32'(dut.state), 32'(WIN_SHOW));
        n = 1;
        tick();
        chk("score_inc_width", score_inc, 0);
        for (int i = 0; i < 50 && sseg_mode; i++) begin
            n++;
            tick();
        end
        chk("sseg_hold_cycles", n, 8);
        chk("win_end_gen_rand", gen_rand, 1);
        chk("win_end_state", 32'(dut.state), 32'(NEW_ROUND));
        tick();
        chk("round2_guesses", guesses_left, 3);

        // three losing guesses
        pulses = 0;
        for (int g = 0; g < 3; g++) begin
            Enter = 1'b1;
            tick();
            Enter = 1'b0;
            tick();
            tick();
            chk("lose_guesses", guesses_left, 32'(2 - g));
            if (score_clr) pulses++;
        end
        chk("lose_state", 32'(dut.state), 32'(LOSE_SHOW));
        chk("lose_sel", sel_bits, 3);
        tick();
        if (score_clr) pulses++;
        chk("score_clr_once", pulses, 1);
        disp_score = 1'b1;
        disp_switches = 1'b1;
        tick();
        tick();
        chk("lose_sel_forced", sel_bits, 3);
        chk("lose_hold_state", 32'(dut.state), 32'(LOSE_SHOW));
        chk("lose_hold_guesses", guesses_left, 0);
        disp_score = 1'b0;
        disp_switches = 1'b0;
        Enter = 1'b1;
        tick();
        chk("lose_exit_gen_rand", gen_rand, 1);
        Enter = 1'b0;
        tick();
        chk("round3_guesses", guesses_left, 3);

        // Enter held for 50 cycles
        Enter = 1'b1;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cmp_en) pulses++;
        end
        chk("held_enter_cmp_count", pulses, 1);
        chk("held_enter_guesses", guesses_left, 2);
        chk("held_enter_state", 32'(dut.state), 32'(GUESS));
        Enter = 1'b0;
        tick();

        // display priority
        disp_score = 1'b1;
        disp_random = 1'b1;
        disp_switches = 1'b1;
        tick();
        chk("prio_all", sel_bits, 0);
        disp_score = 1'b0;
        tick();
        chk("prio_random", sel_bits, 3);
        disp_random = 1'b0;
        tick();
        chk("prio_switches", sel_bits, 1);
        disp_switches = 1'b0;
        tick();
        chk("prio_none", sel_bits, 2);

        // reset mid WIN_SHOW with Enter held
        Enter = 1'b1;
        tick();
        win = 1'b1;
        tick();
        tick();
        win = 1'b0;
        chk("rst_test_win_show", sseg_mode, 1);
        tick();
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midwin_rst_state", 32'(dut.state), 32'(IDLE));
        chk("midwin_rst_outs", {gen_rand, cmp_en, score_inc, score_clr, sseg_mode}, 0);
        chk("midwin_rst_sel", sel_bits, 0);
        chk("midwin_rst_guesses", guesses_left, 0);
        tick();
        tick();
        tick();
        chk("held_thru_rst_state", 32'(dut.state), 32'(IDLE));
        chk("held_thru_rst_gen", gen_rand, 0);
        Enter = 1'b0;
        tick();
        Enter = 1'b1;
        tick();
        chk("repress_gen_rand", gen_rand, 1);
        Enter = 1'b0;
        tick();
        chk("repress_state", 32'(dut.state), 32'(GUESS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
